// File: rtl/layer_sched_pkg.sv
// Shared constants for the layer sequencer and the engines it drives.
package layer_sched_pkg;

    localparam int unsigned ENG_ID_W    = 2;
    localparam int unsigned DRAM_ADDR_W = 18;

    localparam logic [ENG_ID_W-1:0] ENG_CONV = 2'd0;
    localparam logic [ENG_ID_W-1:0] ENG_POOL = 2'd1;
    localparam logic [ENG_ID_W-1:0] ENG_FC   = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BAD_ENG = 2'd2;

    // DRAM regions the engines address: weights, input maps, output maps
    localparam logic [DRAM_ADDR_W-1:0] PARAM_BASE = 18'h00000;
    localparam logic [DRAM_ADDR_W-1:0] IFMAP_BASE = 18'h10000;
    localparam logic [DRAM_ADDR_W-1:0] OFMAP_BASE = 18'h20000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Host, engine and DRAM-side signals of the layer sequencer.
interface layer_sched_if
    import layer_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned NUM_ENG    = 3,
    parameter int unsigned MAX_LAYERS = 8
);
    localparam int unsigned PTR_W = ptr_width(MAX_LAYERS);

    logic                          start;
    logic                          cfg_we;
    logic [PTR_W-1:0]              cfg_idx;
    logic [ENG_ID_W-1:0]           cfg_eng;
    logic [PTR_W:0]                cfg_num;

    logic [NUM_ENG-1:0]            eng_enable;
    logic [NUM_ENG-1:0]            eng_done;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out;
    logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out;
    logic [NUM_ENG-1:0]            eng_en_rd;
    logic [NUM_ENG-1:0]            eng_en_wr;

    logic [ADDR_WIDTH-1:0]         dram_addr_in;
    logic [ADDR_WIDTH-1:0]         dram_addr_out;
    logic [DATA_WIDTH-1:0]         dram_data_out;
    logic                          dram_en_rd;
    logic                          dram_en_wr;

    logic                          busy;
    logic                          done;
    logic                          err;
    logic [1:0]                    err_code;
    logic [PTR_W-1:0]              cur_layer;

    modport master (
        output start, cfg_we, cfg_idx, cfg_eng, cfg_num,
        output eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr,
        input  eng_enable,
        input  dram_addr_in, dram_addr_out, dram_data_out, dram_en_rd, dram_en_wr,
        input  busy, done, err, err_code, cur_layer
    );

    modport slave (
        input  start, cfg_we, cfg_idx, cfg_eng, cfg_num,
        input  eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr,
        output eng_enable,
        output dram_addr_in, dram_addr_out, dram_data_out, dram_en_rd, dram_en_wr,
        output busy, done, err, err_code, cur_layer
    );

endinterface

// File: rtl/layer_sched_dram_port_mux.sv
// NUM_ENG-way selector onto the single DRAM port; all zero when gate_i is low.
module layer_sched_dram_port_mux #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned NUM_ENG    = 3,
    parameter int unsigned SEL_W      = 2
) (
    input  logic [SEL_W-1:0]              sel_i,
    input  logic                          gate_i,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] addr_rd_i,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] addr_wr_i,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] data_wr_i,
    input  logic [NUM_ENG-1:0]            en_rd_i,
    input  logic [NUM_ENG-1:0]            en_wr_i,
    output logic [ADDR_WIDTH-1:0]         addr_rd_o,
    output logic [ADDR_WIDTH-1:0]         addr_wr_o,
    output logic [DATA_WIDTH-1:0]         data_wr_o,
    output logic                          en_rd_o,
    output logic                          en_wr_o
);

    // An out-of-range select matches no engine and leaves the port idle
    always_comb begin
        addr_rd_o = '0;
        addr_wr_o = '0;
        data_wr_o = '0;
        en_rd_o   = 1'b0;
        en_wr_o   = 1'b0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            if (gate_i && (32'(sel_i) == k)) begin
                addr_rd_o = addr_rd_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                addr_wr_o = addr_wr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                data_wr_o = data_wr_i[k*DATA_WIDTH +: DATA_WIDTH];
                en_rd_o   = en_rd_i[k];
                en_wr_o   = en_wr_i[k];
            end
        end
    end

endmodule

// File: rtl/layer_sched.sv
// Walks the programmed layer list, launching one engine at a time and
// lending it the DRAM port until it reports done; watchdog on each layer.
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned NUM_ENG    = 3,
    parameter int unsigned MAX_LAYERS = 8,
    parameter int unsigned TO_WIDTH   = 20
) (
    input logic          clk,
    input logic          srst,
    layer_sched_if.slave bus
);

    localparam int unsigned PTR_W = ptr_width(MAX_LAYERS);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Timeout is taken when the count is about to reach all-ones
    localparam logic [TO_WIDTH-1:0] WD_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic [ENG_ID_W-1:0] sel_q, sel_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ENG_ID_W-1:0] list_q [MAX_LAYERS];
    logic [ENG_ID_W-1:0] list_d [MAX_LAYERS];
    logic [NUM_ENG-1:0]  eng_enable_q, eng_enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                done_sel;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            wd_q         <= '0;
            sel_q        <= '0;
            err_code_q   <= ERR_NONE;
            eng_enable_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
                list_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            wd_q         <= wd_d;
            sel_q        <= sel_d;
            err_code_q   <= err_code_d;
            eng_enable_q <= eng_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            list_q       <= list_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        wd_d         = wd_q;
        err_code_d   = err_code_q;
        list_d       = list_q;
        eng_enable_d = '0;
        done_sel     = |(bus.eng_done & (NUM_ENG'(1) << sel_q));

        // List writes land before a same-cycle start reads slot 0
        if (bus.cfg_we && (state_q == ST_IDLE || state_q == ST_ERR)) begin
            list_d[bus.cfg_idx] = bus.cfg_eng;
        end

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (bus.start) begin
                    cnt_d      = bus.cfg_num;
                    ptr_d      = '0;
                    wd_d       = '0;
                    err_code_d = ERR_NONE;
                    state_d    = (bus.cfg_num == '0) ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (32'(sel_q) >= NUM_ENG) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_BAD_ENG;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + TO_WIDTH'(1);
                if (done_sel) begin
                    if (CNT_W'(ptr_q) == cnt_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + PTR_W'(1);
                        wd_d    = '0;
                        state_d = ST_LAUNCH;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they align with it
        sel_d = (state_d == ST_LAUNCH) ? list_d[ptr_d] : sel_q;
        if (state_d == ST_LAUNCH && 32'(sel_d) < NUM_ENG) begin
            eng_enable_d = NUM_ENG'(1) << sel_d;
        end
        busy_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    assign bus.eng_enable = eng_enable_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.cur_layer  = ptr_q;

    layer_sched_dram_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_ENG    (NUM_ENG),
        .SEL_W      (ENG_ID_W)
    ) u_dram_mux (
        .sel_i     (sel_q),
        .gate_i    (busy_q),
        .addr_rd_i (bus.eng_addr_in),
        .addr_wr_i (bus.eng_addr_out),
        .data_wr_i (bus.eng_data_out),
        .en_rd_i   (bus.eng_en_rd),
        .en_wr_i   (bus.eng_en_wr),
        .addr_rd_o (bus.dram_addr_in),
        .addr_wr_o (bus.dram_addr_out),
        .data_wr_o (bus.dram_data_out),
        .en_rd_o   (bus.dram_en_rd),
        .en_wr_o   (bus.dram_en_wr)
    );

endmodule
